// File: rtl/car_controller.sv
// Car lanes for a frogger-style playfield: per-lane horizontal motion with screen wrap,
// sprite lookup against the current raster pixel, draw priority and per-frame player hits.

module car_rom (
    input  logic [4:0] PixelX,
    input  logic [3:0] PixelY,
    input  logic       Dir,
    output logic [5:0] Pixel
);
    // Sprite is drawn facing right; the caller mirrors PixelX for left-moving cars.
    always_comb begin
        Pixel = Dir ? 6'd12 : 6'd20;
        if (PixelY == 4'd0 || PixelY == 4'd15)
            Pixel = 6'd0;
        else if ((PixelX < 5'd2 || PixelX > 5'd29) && (PixelY < 4'd3 || PixelY > 4'd12))
            Pixel = 6'd0;
        else if (PixelY >= 4'd12 && ((PixelX >= 5'd4 && PixelX <= 5'd9) ||
                                     (PixelX >= 5'd22 && PixelX <= 5'd27)))
            Pixel = 6'd1;
        else if (PixelY >= 4'd3 && PixelY <= 4'd6 && PixelX >= 5'd18 && PixelX <= 5'd25)
            Pixel = 6'd33;
    end
endmodule

module car_controller #(
    parameter int         NUM_LANES              = 4,
    parameter logic [9:0] LANE_Y     [NUM_LANES] = '{10'd128, 10'd176, 10'd288, 10'd336},
    parameter logic [9:0] LANE_X0    [NUM_LANES] = '{10'd100, 10'd300, 10'd500, 10'd200},
    parameter logic [2:0] LANE_SPEED [NUM_LANES] = '{3'd1, 3'd2, 3'd3, 3'd2},
    parameter logic       LANE_DIR   [NUM_LANES] = '{1'b1, 1'b0, 1'b1, 1'b0}
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       VSync,
    input  logic       Blank,
    input  logic       Pause,
    input  logic [9:0] DrawX,
    input  logic [9:0] DrawY,
    input  logic [5:0] P1Pixel,
    input  logic [5:0] P2Pixel,
    input  logic [9:0] P1Bottom,
    input  logic [9:0] P2Bottom,
    output logic [5:0] CarPixel,
    output logic       CarPriority,
    output logic       P1Hit,
    output logic       P2Hit
);
    localparam logic [9:0] WRAP_W = 10'd672;

    logic [9:0]           car_x     [NUM_LANES];
    logic [9:0]           next_x    [NUM_LANES];
    logic [5:0]           rom_pixel [NUM_LANES];
    logic [NUM_LANES-1:0] covers;
    logic                 vsync_q, frame_tick, h1, h2, hit1_now, hit2_now;
    logic [9:0]           car_bottom, ref_bottom;
    logic [5:0]           ref_pixel;

    // The car spans CarX-32..CarX-1, so the column offset from its left edge is
    // DrawX+32-CarX; any wrap or overflow shows up in the offset's upper bits.
    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        logic [10:0] x_off, y_off;
        logic [4:0]  px;

        assign x_off     = {1'b0, DrawX} + 11'd32 - {1'b0, car_x[i]};
        assign y_off     = {1'b0, DrawY} - {1'b0, LANE_Y[i]};
        assign covers[i] = (x_off[10:5] == 6'd0) && (y_off[10:4] == 7'd0);
        assign px        = LANE_DIR[i] ? x_off[4:0] : ~x_off[4:0];

        car_rom u_rom (
            .PixelX (px),
            .PixelY (y_off[3:0]),
            .Dir    (LANE_DIR[i]),
            .Pixel  (rom_pixel[i])
        );
    end

    // NOTE: every always_comb output gets a default before any branch so no latch is inferred.
    always_comb begin
        logic found;
        found      = 1'b0;
        CarPixel   = 6'd0;
        car_bottom = 10'd0;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (!found && covers[i]) begin
                found      = 1'b1;
                CarPixel   = rom_pixel[i];
                car_bottom = LANE_Y[i] + 10'd15;
            end
        end
    end

    always_comb begin
        ref_pixel   = (P1Pixel != 6'd0) ? P1Pixel  : P2Pixel;
        ref_bottom  = (P1Pixel != 6'd0) ? P1Bottom : P2Bottom;
        CarPriority = (CarPixel != 6'd0) && (ref_pixel != 6'd0) && (car_bottom > ref_bottom);
        hit1_now    = Blank && (CarPixel != 6'd0) && (P1Pixel != 6'd0);
        hit2_now    = Blank && (CarPixel != 6'd0) && (P2Pixel != 6'd0);
    end

    always_comb begin
        for (int i = 0; i < NUM_LANES; i++) begin
            next_x[i] = car_x[i];
            if (LANE_DIR[i]) begin
                next_x[i] = car_x[i] + {7'd0, LANE_SPEED[i]};
                if (next_x[i] > WRAP_W - 10'd1)
                    next_x[i] = next_x[i] - WRAP_W;
            end else if (car_x[i] < {7'd0, LANE_SPEED[i]}) begin
                next_x[i] = car_x[i] + WRAP_W - {7'd0, LANE_SPEED[i]};
            end else begin
                next_x[i] = car_x[i] - {7'd0, LANE_SPEED[i]};
            end
        end
    end

    // Hits are pulsed from the accumulated flags during the tick cycle itself.
    assign P1Hit = frame_tick & h1;
    assign P2Hit = frame_tick & h2;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            for (int i = 0; i < NUM_LANES; i++)
                car_x[i] <= LANE_X0[i];
            vsync_q    <= 1'b1;
            frame_tick <= 1'b0;
            h1         <= 1'b0;
            h2         <= 1'b0;
        end else begin
            vsync_q    <= VSync;
            frame_tick <= vsync_q & ~VSync;
            if (frame_tick) begin
                h1 <= hit1_now;
                h2 <= hit2_now;
                if (!Pause)
                    for (int i = 0; i < NUM_LANES; i++)
                        car_x[i] <= next_x[i];
            end else begin
                h1 <= h1 | hit1_now;
                h2 <= h2 | hit2_now;
            end
        end
    end
endmodule

// File: tb/tb_car_controller.sv
// Directed bench for car_controller: a default instance plus one with altered lane
// placement for wrap and lane-overlap cases; expectations flow through a scoreboard queue.

module tb_car_controller;
    logic       Clk = 1'b0;
    logic       Reset, VSync, Blank, Pause;
    logic [9:0] DrawX, DrawY, P1Bottom, P2Bottom;
    logic [5:0] P1Pixel, P2Pixel;
    logic [5:0] car_pixel_a, car_pixel_b;
    logic       prio_a, prio_b, p1_hit_a, p2_hit_a, p1_hit_b, p2_hit_b;

    typedef struct {
        string      tag;
        logic [9:0] value;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    always #5 Clk = ~Clk;

    car_controller dut (
        .Clk(Clk), .Reset(Reset), .VSync(VSync), .Blank(Blank), .Pause(Pause),
        .DrawX(DrawX), .DrawY(DrawY), .P1Pixel(P1Pixel), .P2Pixel(P2Pixel),
        .P1Bottom(P1Bottom), .P2Bottom(P2Bottom), .CarPixel(car_pixel_a),
        .CarPriority(prio_a), .P1Hit(p1_hit_a), .P2Hit(p2_hit_a)
    );

    // Lane 3 is moved up to overlap lane 0; lanes 1 and 2 start next to their wrap points.
    car_controller #(
        .LANE_Y  ('{10'd128, 10'd176, 10'd288, 10'd136}),
        .LANE_X0 ('{10'd100, 10'd1, 10'd670, 10'd110})
    ) dut_b (
        .Clk(Clk), .Reset(Reset), .VSync(VSync), .Blank(Blank), .Pause(Pause),
        .DrawX(DrawX), .DrawY(DrawY), .P1Pixel(P1Pixel), .P2Pixel(P2Pixel),
        .P1Bottom(P1Bottom), .P2Bottom(P2Bottom), .CarPixel(car_pixel_b),
        .CarPriority(prio_b), .P1Hit(p1_hit_b), .P2Hit(p2_hit_b)
    );

    task automatic push_exp(input string tag, input logic [9:0] value);
        exp_t e;
        e.tag   = tag;
        e.value = value;
        sb.push_back(e);
    endtask

    task automatic check(input logic [9:0] obs);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            failures++;
            $error("FAIL scoreboard_empty: observed=%0d expected=<none>", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.value)
            else begin
                failures++;
                $error("FAIL %s: observed=%0d expected=%0d", e.tag, obs, e.value);
            end
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic set_pixel(input logic [9:0] x, input logic [9:0] y);
        DrawX = x;
        DrawY = y;
        #2;
    endtask

    task automatic overlap(input logic blank, input logic [5:0] p1, input logic [5:0] p2);
        Blank   = blank;
        DrawX   = 10'd84;
        DrawY   = 10'd140;
        P1Pixel = p1;
        P2Pixel = p2;
        repeat (3) step();
        Blank   = 1'b0;
        DrawX   = 10'd0;
        DrawY   = 10'd0;
        P1Pixel = 6'd0;
        P2Pixel = 6'd0;
        step();
    endtask

    task automatic do_reset();
        Reset = 1'b0;
        repeat (2) step();
        Reset = 1'b1;
        step();
    endtask

    initial begin
        Reset = 1'b0; VSync = 1'b1; Blank = 1'b0; Pause = 1'b0;
        DrawX = 10'd84; DrawY = 10'd140;
        P1Pixel = 6'd0; P2Pixel = 6'd0; P1Bottom = 10'd0; P2Bottom = 10'd0;
        repeat (2) step();

        push_exp("rst_lane0_x", 10'd100); check(dut.car_x[0]);
        push_exp("rst_lane2_x", 10'd500); check(dut.car_x[2]);
        push_exp("rst_p1hit", 10'd0);     check({9'd0, p1_hit_a});
        push_exp("rst_p2hit", 10'd0);     check({9'd0, p2_hit_a});
        push_exp("rst_carpixel", 10'd12); check({4'd0, car_pixel_a});

        Reset = 1'b1;
        step();

        // Sprite lookup and car extents at the reset positions.
        set_pixel(10'd84, 10'd140);  push_exp("pix_body", 10'd12);        check({4'd0, car_pixel_a});
        set_pixel(10'd280, 10'd180); push_exp("pix_mirror", 10'd33);      check({4'd0, car_pixel_a});
        set_pixel(10'd67, 10'd140);  push_exp("pix_left_out", 10'd0);     check({4'd0, car_pixel_a});
        set_pixel(10'd68, 10'd140);  push_exp("pix_left_in", 10'd12);     check({4'd0, car_pixel_a});
        set_pixel(10'd99, 10'd140);  push_exp("pix_right_in", 10'd12);    check({4'd0, car_pixel_a});
        set_pixel(10'd100, 10'd140); push_exp("pix_right_out", 10'd0);    check({4'd0, car_pixel_a});
        set_pixel(10'd84, 10'd128);  push_exp("pix_transparent", 10'd0);  check({4'd0, car_pixel_a});
        set_pixel(10'd84, 10'd144);  push_exp("pix_below", 10'd0);        check({4'd0, car_pixel_a});
        set_pixel(10'd84, 10'd140);  push_exp("pix_lowest_lane", 10'd12); check({4'd0, car_pixel_b});
        set_pixel(10'd105, 10'd140); push_exp("pix_lane3_only", 10'd20);  check({4'd0, car_pixel_b});

        // Draw priority against the reference player.
        set_pixel(10'd84, 10'd140);
        P1Pixel = 6'd5; P1Bottom = 10'd130; #2;
        push_exp("prio_p1_above", 10'd1); check({9'd0, prio_a});
        P1Bottom = 10'd150; #2;
        push_exp("prio_p1_below", 10'd0); check({9'd0, prio_a});
        P2Pixel = 6'd7; P2Bottom = 10'd130; #2;
        push_exp("prio_ref_is_p1", 10'd0); check({9'd0, prio_a});
        P1Pixel = 6'd0; #2;
        push_exp("prio_ref_is_p2", 10'd1); check({9'd0, prio_a});
        set_pixel(10'd67, 10'd140);
        push_exp("prio_no_car", 10'd0); check({9'd0, prio_a});
        P2Pixel = 6'd0; P1Bottom = 10'd0; P2Bottom = 10'd0;

        // P1 overlap during active video, then one frame tick.
        overlap(1'b1, 6'd5, 6'd0);
        VSync = 1'b0;
        step();
        push_exp("hit1_tick", 10'd1);        check({9'd0, p1_hit_a});
        push_exp("hit2_tick", 10'd0);        check({9'd0, p2_hit_a});
        push_exp("lane0_before_upd", 10'd100); check(dut.car_x[0]);
        step();
        VSync = 1'b1;
        push_exp("hit1_after_tick", 10'd0);  check({9'd0, p1_hit_a});
        push_exp("lane0_move_right", 10'd101); check(dut.car_x[0]);
        push_exp("lane1_move_left", 10'd298);  check(dut.car_x[1]);
        push_exp("lane2_wrap_right", 10'd1);   check(dut_b.car_x[2]);
        push_exp("lane1_wrap_left", 10'd671);  check(dut_b.car_x[1]);
        step();

        // Next frame with no overlap: no pulse.
        VSync = 1'b0;
        step();
        push_exp("hit1_quiet_frame", 10'd0); check({9'd0, p1_hit_a});
        step();
        VSync = 1'b1;
        step();

        // Overlap outside active video is ignored. Lane 0 is now at 102: (84,140) still covered.
        overlap(1'b0, 6'd5, 6'd5);
        VSync = 1'b0;
        step();
        push_exp("hit1_blanked", 10'd0); check({9'd0, p1_hit_a});
        push_exp("hit2_blanked", 10'd0); check({9'd0, p2_hit_a});
        step();
        VSync = 1'b1;
        step();

        // P2-only overlap.
        overlap(1'b1, 6'd0, 6'd9);
        VSync = 1'b0;
        step();
        push_exp("hit2_only_p2", 10'd1); check({9'd0, p2_hit_a});
        push_exp("hit1_only_p2", 10'd0); check({9'd0, p1_hit_a});
        step();
        VSync = 1'b1;
        step();

        // Pause freezes motion but not collisions.
        do_reset();
        Pause = 1'b1;
        overlap(1'b1, 6'd5, 6'd0);
        VSync = 1'b0;
        step();
        push_exp("hit1_paused", 10'd1); check({9'd0, p1_hit_a});
        step();
        VSync = 1'b1;
        push_exp("lane1_paused", 10'd1);   check(dut_b.car_x[1]);
        push_exp("lane0_paused", 10'd100); check(dut.car_x[0]);
        Pause = 1'b0;
        step();

        // Reset landing on the update cycle aborts the move; the next tick moves normally.
        VSync = 1'b0;
        step();
        Reset = 1'b0;
        step();
        push_exp("lane0_reset_abort", 10'd100); check(dut.car_x[0]);
        push_exp("hit1_reset_abort", 10'd0);    check({9'd0, p1_hit_a});
        VSync = 1'b1;
        Reset = 1'b1;
        repeat (2) step();
        VSync = 1'b0;
        repeat (2) step();
        VSync = 1'b1;
        push_exp("lane0_after_release", 10'd101); check(dut.car_x[0]);
        step();

        if (sb.size() != 0) begin
            failures++;
            $error("FAIL scoreboard_leftover: observed=%0d expected=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/car_controller.md
CAR_CONTROLLER -- requirements
Module: car_controller

Interface
REQ-001 SHALL have parameter NUM_LANES, 4, number of car lanes, one car per lane.
REQ-002 SHALL have parameter LANE_Y, '{128,176,288,336}, 10-bit top row of each lane's car.
REQ-003 SHALL have parameter LANE_X0, '{100,300,500,200}, 10-bit reset position per lane.
REQ-004 SHALL have parameter LANE_SPEED, '{1,2,3,2}, 3-bit pixels per frame per lane.
REQ-005 SHALL have parameter LANE_DIR, '{1,0,1,0}, 1 = moving right, 0 = moving left.
REQ-006 SHALL have port Clk, input, 1, system clock; single clock domain.
REQ-007 SHALL have port Reset, input, 1, synchronous, active-low reset.
REQ-008 SHALL have port VSync, input, 1, VGA vertical sync, active low.
REQ-009 SHALL have port Blank, input, 1, high during active video.
REQ-010 SHALL have port Pause, input, 1, freezes car motion.
REQ-011 SHALL have port DrawX/DrawY, input, 10 each, current pixel.
REQ-012 SHALL have port P1Pixel/P2Pixel, input, 6 each, player palette index; 0 = transparent.
REQ-013 SHALL have port P1Bottom/P2Bottom, input, 10 each, player hitbox bottom row.
REQ-014 SHALL have port CarPixel, output, 6, car palette index; 0 = no car.
REQ-015 SHALL have port CarPriority, output, 1, car drawn over player.
REQ-016 SHALL have port P1Hit/P2Hit, output, 1 each, one-cycle collision pulses.

Function
REQ-017 SHALL hold a 10-bit CarX per lane in 0..671; the car occupies screen columns CarX-32..CarX-1, 32 wide x 16 tall.
REQ-018 SHALL register VSync and raise a frame tick for one cycle on each 1->0 transition.
REQ-019 SHALL, in the cycle after the frame tick, update every CarX unless Pause=1: right-moving lanes use CarX+speed, left-moving lanes use CarX-speed.
REQ-020 SHALL wrap right-moving lanes: if CarX+speed > 671, CarX = CarX+speed-672.
REQ-021 SHALL wrap left-moving lanes: if CarX < speed, CarX = CarX+672-speed.
REQ-022 SHALL compute CarPixel combinationally from registered CarX and current DrawX/DrawY with zero-cycle latency. The sprite comes from car_rom (PixelX 5-bit, PixelY 4-bit, Dir), and left-moving cars use the mirrored PixelX.
REQ-023 SHALL use the lowest-index lane's car when more than one lane covers a pixel.
REQ-024 SHALL force CarPixel to 0 when the ROM returns 0 or the pixel is outside every car.
REQ-025 SHALL select the reference player as P1 if P1Pixel != 0, else P2.
REQ-026 SHALL set CarPriority=1 iff CarPixel != 0, the reference player's pixel != 0, and the covering car's bottom row (LANE_Y+15) > that player's Bottom; otherwise 0.
REQ-027 SHALL set the internal flag h1 when Blank=1, CarPixel != 0 and P1Pixel != 0; h2 is set the same way using P2Pixel.
REQ-028 SHALL accumulate h1/h2 over the frame. On the frame tick it SHALL drive P1Hit=h1 and P2Hit=h2 for exactly that cycle and clear h1/h2 in the same cycle.
REQ-029 SHALL ignore overlaps while Blank=0.
REQ-030 SHALL not let Pause affect collision accumulation or pulses.

Reset
REQ-031 SHALL, while Reset=0 at a Clk edge, load CarX=LANE_X0, clear h1/h2 and P1Hit/P2Hit, and set the VSync register to 1.
REQ-032 SHALL abort any pending position update or hit pulse when Reset is asserted mid-frame; the first frame tick after release updates positions normally.
REQ-033 SHALL derive CarPixel/CarPriority combinationally from reset positions during reset.

Verification
REQ-034 SHALL cover: Reset=0 for 2 cycles -> lane0 CarX=100, lane2 CarX=500, P1Hit=P2Hit=0.
REQ-035 SHALL cover: lane2 (right, speed 3) CarX=670, one VSync 1->0 -> CarX=1 one cycle after the tick.
REQ-036 SHALL cover: lane1 (left, speed 2) CarX=1, one frame tick -> CarX=671; with Pause=1 instead -> CarX stays 1.
REQ-037 SHALL cover: Blank=1, DrawX=CarX0-16, DrawY=140, P1Pixel=5 during the frame -> P1Hit=1 for exactly the frame-tick cycle, P2Hit=0, then P1Hit=0 the next frame if no overlap occurs.
REQ-038 SHALL cover: car pixel in lane0 (bottom 143), P1Pixel=5, P1Bottom=130 -> CarPriority=1; P1Bottom=150 -> CarPriority=0.
REQ-039 SHALL cover: the same overlap with Blank=0 -> no hit pulse at the next frame tick.
